ebi_vram_write_scheduler: RTL and testbench

Sits between ebi_interface and the shared video memory write port. Buffers MCU writes (address_out/data_out/data_ready) in a small FIFO and decodes each write into a memory region or a local control register. Arbitrates the single memory port between buffered MCU writes and the renderer. The renderer has priority; MCU writes drain whenever the port is free.

---
 rtl/ebi_vram_write_scheduler_pkg.sv | 26 ++
 rtl/ebi_vram_write_scheduler_sync_fifo.sv | 60 ++++++
 rtl/ebi_vram_write_scheduler.sv | 146 ++++++++++++++
 tb/tb_ebi_vram_write_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ebi_vram_write_scheduler_pkg.sv
// Shared types for the EBI video-memory write scheduler: regions, scheduler states
// and the buffered write entry.
package ebi_pkg;

    localparam int EBI_AW = 16;
    localparam int EBI_DW = 16;

    typedef enum logic [1:0] {
        REG_TILE = 2'b00,
        REG_OAM  = 2'b01,
        REG_PAL  = 2'b10,
        REG_CTRL = 2'b11
    } region_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RENDER
    } sched_state_t;

    typedef struct packed {
        logic [EBI_AW-1:0] addr;
        logic [EBI_DW-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/ebi_vram_write_scheduler_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = storage[rd_ptr];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ebi_vram_write_scheduler.sv
// Buffers MCU writes, decodes them into memory regions or control registers and shares
// the memory write port with the renderer. Optional drop counter: EBI_DROP_COUNT_EN.
module ebi_vram_write_scheduler
    import ebi_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int NUM_CTRL_REGS = 4,
    parameter int MEM_AW        = 14
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [15:0]                     address_in,
    input  logic [15:0]                     data_in,
    input  logic                            data_ready,
    input  logic                            render_req,
    input  logic                            overflow_clr,
    output logic                            render_grant,
    output logic                            mem_we,
    output logic [1:0]                      mem_region,
    output logic [MEM_AW-1:0]               mem_addr,
    output logic [15:0]                     mem_wdata,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [NUM_CTRL_REGS*16-1:0]     ctrl_regs
`ifdef EBI_DROP_COUNT_EN
    ,
    output logic [7:0]                      drop_count
`endif
);

    sched_state_t state;
    sched_state_t next_state;
    fifo_entry_t  push_entry;
    fifo_entry_t  head;
    region_t      head_region;
    logic [3:0]   ctrl_idx;
    logic         ctrl_idx_ok;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         do_mem;
    logic         do_ctrl;
    logic         drop;

    assign push_entry  = '{addr: address_in, data: data_in};
    assign head_region = region_t'(head.addr[15:14]);
    assign ctrl_idx    = head.addr[3:0];
    assign ctrl_idx_ok = (int'(ctrl_idx) < NUM_CTRL_REGS);
    assign drop        = data_ready && fifo_full && !pop;

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_ready),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Renderer wins in IDLE; otherwise the FIFO head is consumed. Control writes
    // complete in place so back-to-back control writes run one per cycle.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        do_mem     = 1'b0;
        do_ctrl    = 1'b0;
        case (state)
            IDLE: begin
                if (render_req) begin
                    next_state = RENDER;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_region == REG_CTRL) begin
                        do_ctrl = ctrl_idx_ok;
                    end else begin
                        do_mem     = 1'b1;
                        next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                next_state = IDLE;
            end
            RENDER: begin
                if (!render_req) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            render_grant <= 1'b0;
            mem_we       <= 1'b0;
            mem_region   <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            overflow     <= 1'b0;
            ctrl_regs    <= '0;
        end else begin
            state        <= next_state;
            render_grant <= (next_state == RENDER);
            mem_we       <= do_mem;
            if (do_mem) begin
                mem_region <= head.addr[15:14];
                mem_addr   <= head.addr[MEM_AW-1:0];
                mem_wdata  <= head.data;
            end
            for (int i = 0; i < NUM_CTRL_REGS; i++) begin
                if (do_ctrl && (ctrl_idx == 4'(i))) begin
                    ctrl_regs[i*16 +: 16] <= head.data;
                end
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef EBI_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (overflow_clr) begin
            drop_count <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ebi_vram_write_scheduler.sv
// Scoreboard bench for ebi_vram_write_scheduler: directed scenarios plus random traffic
// checked against a queue-based reference model of the write buffer and port owner.
module tb_ebi_vram_write_scheduler;

    logic        clk;
    logic        reset;
    logic [15:0] address_in;
    logic [15:0] data_in;
    logic        data_ready;
    logic        render_req;
    logic        overflow_clr;
    logic        render_grant;
    logic        mem_we;
    logic [1:0]  mem_region;
    logic [13:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [63:0] ctrl_regs;
`ifdef EBI_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    ebi_vram_write_scheduler #(
        .FIFO_DEPTH    (8),
        .NUM_CTRL_REGS (4),
        .MEM_AW        (14)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address_in   (address_in),
        .data_in      (data_in),
        .data_ready   (data_ready),
        .render_req   (render_req),
        .overflow_clr (overflow_clr),
        .render_grant (render_grant),
        .mem_we       (mem_we),
        .mem_region   (mem_region),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .ctrl_regs    (ctrl_regs)
`ifdef EBI_DROP_COUNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } entry_t;

    // Reference model: pending writes, who owns the port, and architectural registers.
    entry_t      m_q[$];
    logic [31:0] exp_q[$];
    bit          m_writing;
    bit          m_granted;
    bit          m_ovf;
    int          m_drops;
    logic [15:0] m_ctrl [4];
    bit          model_valid = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_ctrl_word();
        logic [63:0] w;
        for (int i = 0; i < 4; i++) w[i*16 +: 16] = m_ctrl[i];
        return w;
    endfunction

    // Advance the model by one clock edge using the inputs just sampled.
    task automatic model_step();
        bit     was_full;
        bit     popped;
        bit     dropped;
        entry_t e;
        was_full = (m_q.size() == 8);
        popped   = 0;
        dropped  = 0;
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            m_writing = 0;
            m_granted = 0;
            m_ovf     = 0;
            m_drops   = 0;
            for (int i = 0; i < 4; i++) m_ctrl[i] = 16'h0;
            model_valid = 1;
            return;
        end
        if (m_writing) begin
            m_writing = 0;
        end else if (m_granted) begin
            if (!render_req) m_granted = 0;
        end else if (render_req) begin
            m_granted = 1;
        end else if (m_q.size() > 0) begin
            popped = 1;
            e = m_q.pop_front();
            if (e.a[15:14] != 2'b11) m_writing = 1;
            else if (e.a[3:0] < 4) m_ctrl[e.a[1:0]] = e.d;
        end
        if (data_ready) begin
            if (was_full && !popped) begin
                dropped = 1;
            end else begin
                e.a = address_in;
                e.d = data_in;
                m_q.push_back(e);
                if (address_in[15:14] != 2'b11) exp_q.push_back({address_in, data_in});
            end
        end
        if (dropped) m_ovf = 1;
        else if (overflow_clr) m_ovf = 0;
        if (overflow_clr) m_drops = dropped ? 1 : 0;
        else if (dropped && m_drops < 255) m_drops++;
    endtask

    task automatic applyStimulus(input logic rst, input logic dr, input logic [15:0] a,
                                 input logic [15:0] d, input logic rr, input logic clr);
        reset        = rst;
        data_ready   = dr;
        address_in   = a;
        data_in      = d;
        render_req   = rr;
        overflow_clr = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Monitor: compares registered outputs to the model and drains the write scoreboard.
    always @(negedge clk) begin
        logic [31:0] w;
        if (model_valid) begin
            checkOutput("mem_we", {63'b0, mem_we}, {63'b0, m_writing});
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 64'd1, 64'd0);
                end else begin
                    w = exp_q.pop_front();
                    checkOutput("write_content", {32'b0, mem_region, mem_addr, mem_wdata}, {32'b0, w});
                end
            end
            checkOutput("render_grant", {63'b0, render_grant}, {63'b0, m_granted});
            checkOutput("fifo_level", {60'b0, fifo_level}, 64'(m_q.size()));
            checkOutput("overflow", {63'b0, overflow}, {63'b0, m_ovf});
            checkOutput("ctrl_regs", ctrl_regs, model_ctrl_word());
`ifdef EBI_DROP_COUNT_EN
            checkOutput("drop_count", {56'b0, drop_count}, 64'(m_drops));
`endif
        end
    end

    task automatic idle_cycles(input int n, input logic rr);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 16'h0, 16'h0, rr, 0);
    endtask

    initial begin
        logic       rr;
        logic [1:0] reg_sel;
        logic [13:0] low;
        reset = 1; data_ready = 0; address_in = 0; data_in = 0; render_req = 0; overflow_clr = 0;
        applyStimulus(1, 0, 16'h0, 16'h0, 0, 0);
        applyStimulus(1, 0, 16'h0, 16'h0, 0, 0);
        checkOutput("reset_fifo_level", {60'b0, fifo_level}, 64'd0);
        checkOutput("reset_ctrl_regs", ctrl_regs, 64'd0);

        // Tile write: strobe appears two cycles after data_ready.
        applyStimulus(0, 1, 16'h0005, 16'h0032, 0, 0);
        checkOutput("t1_not_early", {63'b0, mem_we}, 64'd0);
        idle_cycles(1, 0);
        checkOutput("t1_mem_we", {63'b0, mem_we}, 64'd1);
        checkOutput("t1_region", {62'b0, mem_region}, 64'd0);
        checkOutput("t1_addr", {50'b0, mem_addr}, 64'h0005);
        checkOutput("t1_wdata", {48'b0, mem_wdata}, 64'h0032);
        checkOutput("t1_level", {60'b0, fifo_level}, 64'd0);

        // Control register writes, including an out-of-range index.
        applyStimulus(0, 1, 16'hC002, 16'hABCD, 0, 0);
        idle_cycles(1, 0);
        checkOutput("t2_ctrl2", {48'b0, ctrl_regs[47:32]}, 64'hABCD);
        applyStimulus(0, 1, 16'hC00F, 16'h1234, 0, 0);
        idle_cycles(2, 0);
        checkOutput("t2_ctrl_bad_idx", ctrl_regs, 64'h0000_ABCD_0000_0000);

        // Writes buffered while the renderer owns the port, then drained in order.
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 0);
        applyStimulus(0, 1, 16'h4001, 16'h0011, 1, 0);
        applyStimulus(0, 1, 16'h4002, 16'h0022, 1, 0);
        applyStimulus(0, 1, 16'h8003, 16'h0033, 1, 0);
        idle_cycles(6, 1);
        checkOutput("t3_level", {60'b0, fifo_level}, 64'd3);
        checkOutput("t3_grant", {63'b0, render_grant}, 64'd1);
        idle_cycles(10, 0);

        // Overflow: nine strobes into an eight-entry buffer that cannot drain.
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 16'h0010 + 16'(i), 16'h0100 + 16'(i), 1, 0);
        checkOutput("t4_level_full", {60'b0, fifo_level}, 64'd8);
        checkOutput("t4_overflow", {63'b0, overflow}, 64'd1);
`ifdef EBI_DROP_COUNT_EN
        checkOutput("t4_drop_count", {56'b0, drop_count}, 64'd1);
`endif
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 1);
        checkOutput("t4_overflow_clr", {63'b0, overflow}, 64'd0);
        idle_cycles(24, 0);

        // Renderer request arriving while a write strobe is on the port.
        applyStimulus(0, 1, 16'h0100, 16'h0055, 0, 0);
        idle_cycles(1, 0);
        checkOutput("t5_mem_we", {63'b0, mem_we}, 64'd1);
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 0);
        checkOutput("t5_grant_wait", {63'b0, render_grant}, 64'd0);
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 0);
        checkOutput("t5_grant", {63'b0, render_grant}, 64'd1);
        idle_cycles(3, 0);

        // Reset while entries are buffered.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'h2000 + 16'(i), 16'h0A00 + 16'(i), 1, 0);
        checkOutput("t6_level_before", {60'b0, fifo_level}, 64'd4);
        applyStimulus(1, 0, 16'h0, 16'h0, 1, 0);
        checkOutput("t6_level", {60'b0, fifo_level}, 64'd0);
        checkOutput("t6_mem_we", {63'b0, mem_we}, 64'd0);
        checkOutput("t6_grant", {63'b0, render_grant}, 64'd0);
        checkOutput("t6_ctrl", ctrl_regs, 64'd0);

        // Random traffic against the model.
        rr = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) rr = ~rr;
            reg_sel = 2'($urandom_range(0, 3));
            low     = (reg_sel == 2'b11) ? 14'($urandom_range(0, 7)) : 14'($urandom);
            applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 1),
                          {reg_sel, low}, 16'($urandom), rr, ($urandom_range(0, 19) == 0));
        end
        idle_cycles(40, 0);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
